// File: rtl/mux16_serializer_if.sv
// Handshake and mux16 side-channel bundle for mux16_serializer.
// The master side is the surroundings (upstream, downstream and mux16); the slave side is the serializer.
interface mux16_serializer_if;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  mux_sel;
  logic [15:0] mux_src;
  logic        mux_result;
  logic        ser_valid;
  logic        ser_bit;
  logic        ser_last;
  logic        ser_ready;
  logic        busy;

  modport master (
    output load_valid, load_data, ser_ready, mux_result,
    input  load_ready, mux_sel, mux_src, ser_valid, ser_bit, ser_last, busy
  );

  modport slave (
    input  load_valid, load_data, ser_ready, mux_result,
    output load_ready, mux_sel, mux_src, ser_valid, ser_bit, ser_last, busy
  );
endinterface

// File: rtl/mux16_serializer.sv
// Word-to-bit sequencer in front of mux16: holds the active word on src, walks sel 0..15,
// and returns mux16's result as a handshaked LSB-first bit stream with a one-word pending buffer.
module mux16_serializer (
  input  logic              clk,
  input  logic              rst,
  mux16_serializer_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] next_q, next_d;
  logic [3:0]  sel_q, sel_d;
  logic        next_full_q, next_full_d;

  logic load_ready;
  logic load_fire;
  logic bit_fire;
  logic at_last;

  assign load_ready = (state_q == IDLE) || !next_full_q;
  assign load_fire  = bus.load_valid && load_ready;
  assign bit_fire   = (state_q == SHIFT) && bus.ser_ready;
  assign at_last    = (sel_q == 4'd15);

  // NOTE: every signal written here gets its default first, so no path leaves one unassigned and a latch cannot be inferred.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    next_d      = next_q;
    sel_d       = sel_q;
    next_full_d = next_full_q;

    case (state_q)
      IDLE: begin
        if (load_fire) begin
          hold_d  = bus.load_data;
          sel_d   = 4'd0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_fire && at_last) begin
          sel_d = 4'd0;
          // A pending word wins; only with next_q empty can a same-cycle load bypass it.
          if (next_full_q) begin
            hold_d      = next_q;
            next_full_d = 1'b0;
          end else if (load_fire) begin
            hold_d = bus.load_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (bit_fire) begin
            sel_d = sel_q + 4'd1;
          end
          if (load_fire) begin
            next_d      = bus.load_data;
            next_full_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      next_q      <= '0;
      sel_q       <= '0;
      next_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      next_q      <= next_d;
      sel_q       <= sel_d;
      next_full_q <= next_full_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.mux_sel    = sel_q;
  assign bus.mux_src    = hold_q;
  assign bus.ser_valid  = (state_q == SHIFT);
  assign bus.ser_bit    = bus.mux_result;
  assign bus.ser_last   = (state_q == SHIFT) && at_last;
  assign bus.busy       = (state_q == SHIFT);

endmodule
